rtp_rx_depacketizer: RTL
========================

// Module: rtp_rx_depacketizer
// PURPOSE
//  Receive-side counterpart of the RTP packetizer: consumes UDP payload bytes from the Ethernet stack,
//  validates the 12-byte RTP header, unpacks big-endian 16-bit PCM samples into a jitter FIFO and
//  serves them to the WM8731 playback path (wav_out_data / wav_rden). Sits between ethernet_test
//  udp_rec_* outputs and mywav play inputs, in the clk (50 MHz) domain.
// PARAMETERS
//  RTP_PT      7'd0    required RTP payload type (byte1[6:0])
//  SSRC        32'h12345678  required SSRC; mismatch -> packet dropped
//  FIFO_AW     11      sample FIFO address width (depth 2**FIFO_AW samples)
//  PREFILL     474     samples buffered before playback (re)starts (one 960-byte packet)
//  BYTE_TO     1024    max cycles between bytes inside a packet before abort
// PORTS
//  clk                  in   1         system clock
//  rst_n                in   1         synchronous active-low reset
//  udp_rec_data_valid   in   1         one payload byte present on udp_rec_rdata this cycle
//  udp_rec_rdata        in   8         payload byte, RTP header first
//  udp_rec_data_length  in   16        UDP payload bytes of current packet; sampled on first byte
//  wav_rden             in   1         playback requests next sample
//  wav_out_data         out  16        sample to DAC; updated the cycle after wav_rden
//  playing              out  1         1 = FIFO serving samples, 0 = prefilling
//  fifo_level           out  FIFO_AW+1 samples currently buffered
//  pkt_drop_cnt         out  16        packets rejected (short, bad header, bad SSRC, timeout)
//  seq_gap_cnt          out  16        accepted packets whose seq != expected
//  underrun_cnt         out  16        wav_rden while playing and FIFO empty
//  overflow_cnt         out  16        samples discarded because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, playing=0, expected-seq invalid. Counters saturate at FFFF.
//  FSM IDLE: first valid byte -> latch length L, byte_idx=0, check byte0==8'h80 -> HDR.
//   L<14 -> DROP immediately (no payload sample possible).
//  HDR (idx 0..11): byte1[6:0]==RTP_PT; bytes2-3 = seq (big-endian); bytes8-11 compared to SSRC.
//   Any mismatch -> DROP. On idx 11 OK -> PAYLOAD; seq check: if expected valid and seq!=expected,
//   seq_gap_cnt++; expected=seq+1 mod 2^16, expected-valid set.
//  PAYLOAD: even payload byte = sample[15:8], odd byte = sample[7:0]; push on odd byte.
//   Trailing odd byte (L-12 odd) discarded. Packet ends when idx==L-1 -> IDLE.
//  DROP: swallow bytes until idx==L-1 -> IDLE; pkt_drop_cnt++ once per packet on entry.
//  Timeout: in HDR/PAYLOAD/DROP, BYTE_TO cycles without valid -> IDLE; pkt_drop_cnt++ (unless already
//   counted in DROP). Samples already pushed from the aborted packet stay in FIFO.
//  Push when full: sample discarded, overflow_cnt++. Push and pop same cycle: both happen, level unchanged.
//  playing: 0->1 when fifo_level>=PREFILL; 1->0 on underrun. Prefill ignores wav_rden (no pop,
//   wav_out_data<=0). Playing & empty on wav_rden: wav_out_data<=0, underrun_cnt++, playing<=0.
//  wav_out_data registered, latency 1 from wav_rden; holds value when wav_rden=0.
//  fifo_level reflects pushes/pops of previous cycle (registered).
//  udp_rec_data_length changes mid-packet are ignored (latched copy used).
// STRUCTURE
//  rtp_defs.vh: RTP_HDR_BYTES=12, RTP_VPXCC=8'h80, header byte offsets (SEQ_HI=2, SEQ_LO=3,
//   SSRC0=8..11) shared with the TX packetizer.
//  Sub-module audio_sample_fifo: synchronous 16-bit FIFO, FIFO_AW wide, push/pop/full/empty/level,
//   wrap-around pointers with extra MSB. Parser FSM, seq tracker, prefill control in top.
// TESTING
//  1 Valid pkt L=960, hdr 80 00 0001 .. 12345678, payload 0x1234,0x5678.. -> 474 samples pushed,
//    level=474, playing=1; wav_rden pops 0x1234 then 0x5678, one cycle latency.
//  2 byte0=0x90 or SSRC=0xDEADBEEF -> pkt_drop_cnt=1, level unchanged, next valid pkt accepted.
//  3 Seq 0xFFFF then 0x0000 -> seq_gap_cnt=0; then 0x0002 -> seq_gap_cnt=1.
//  4 Prefill: one pkt, drain 474 + 1 extra wav_rden -> wav_out_data=0, underrun_cnt=1, playing=0;
//    further rden gives 0 with no counter change until level>=474 again.
//  5 Fill 2048 then push 474 more with no rden -> overflow_cnt=474, level=2048; push+pop same cycle
//    at full -> level stays 2048, overflow_cnt unchanged.
//  6 Odd L=15 -> 1 sample pushed, last byte dropped; valid stalls 1024 cycles mid-pkt -> IDLE,
//    pkt_drop_cnt++; rst_n=0 mid-packet -> all outputs 0, FIFO empty next cycle.

Source files
------------

// File: rtl/rtp_rx_depacketizer_pkg.sv
// RTP receive definitions shared by the depacketizer and its sample FIFO.
// Header offsets match the TX packetizer layout.
package rtp_rx_depacketizer_pkg;

  localparam logic [15:0] RTP_HDR_BYTES = 16'd12;
  localparam logic [7:0]  RTP_VPXCC     = 8'h80;
  localparam logic [15:0] PT_IDX        = 16'd1;
  localparam logic [15:0] SEQ_HI        = 16'd2;
  localparam logic [15:0] SEQ_LO        = 16'd3;
  localparam logic [15:0] SSRC0         = 16'd8;
  localparam logic [15:0] HDR_LAST      = RTP_HDR_BYTES - 16'd1;
  localparam logic [15:0] MIN_LEN       = RTP_HDR_BYTES + 16'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_DROP
  } rx_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // SSRC byte i (0 = most significant) as it appears on the wire
  function automatic logic [7:0] ssrc_byte(input logic [31:0] s,
                                           input logic [1:0] i);
    logic [31:0] t;
    t = s << {i, 3'b000};
    return t[31:24];
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous 16-bit sample FIFO with extra-MSB wrap pointers.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module audio_sample_fifo #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [15:0]   din,
  input  logic          pop,
  output logic [15:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [15:0] mem [2**AW];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign level = wr_ptr - rd_ptr;
  assign full  = level[AW];
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rtp_rx_depacketizer.sv
// RTP receive path: header check, seq tracking, PCM unpack into a
// jitter FIFO and prefill-gated playback toward the DAC.
module rtp_rx_depacketizer #(
  parameter logic [6:0]  RTP_PT  = 7'd0,
  parameter logic [31:0] SSRC    = 32'h12345678,
  parameter int          FIFO_AW = 11,
  parameter int          PREFILL = 474,
  parameter int          BYTE_TO = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               udp_rec_data_valid,
  input  logic [7:0]         udp_rec_rdata,
  input  logic [15:0]        udp_rec_data_length,
  input  logic               wav_rden,
  output logic [15:0]        wav_out_data,
  output logic               playing,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        pkt_drop_cnt,
  output logic [15:0]        seq_gap_cnt,
  output logic [15:0]        underrun_cnt,
  output logic [15:0]        overflow_cnt
);
  import rtp_rx_depacketizer_pkg::*;

  localparam int TOW = $clog2(BYTE_TO + 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(BYTE_TO - 1);
  localparam int LW = FIFO_AW + 1;
  localparam logic [LW-1:0] PRE_LVL = LW'(PREFILL);

  rx_state_t      state;
  rx_state_t      state_n;
  logic [15:0]    len;
  logic [15:0]    idx;
  logic [15:0]    seq;
  logic [15:0]    exp_seq;
  logic           exp_valid;
  logic [7:0]     hi;
  logic [TOW-1:0] to_cnt;
  logic           push;
  logic           drop_inc;
  logic           hdr_done;
  logic           last;
  logic           timeout;
  logic           hdr_bad;
  logic           pop_req;
  logic           full;
  logic           empty;
  logic [15:0]    head;
  logic [LW-1:0]  level;

  assign pop_req    = playing && wav_rden;
  assign fifo_level = level;

  audio_sample_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({hi, udp_rec_rdata}),
    .pop   (pop_req),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    drop_inc = 1'b0;
    hdr_done = 1'b0;
    last     = (idx == len - 16'd1);
    timeout  = (state != S_IDLE) && !udp_rec_data_valid
            && (to_cnt == TO_MAX);
    hdr_bad  = ((idx == PT_IDX) && (udp_rec_rdata[6:0] != RTP_PT))
            || ((idx >= SSRC0)
                && (udp_rec_rdata != ssrc_byte(SSRC, idx[1:0])));
    unique case (state)
      S_IDLE: begin
        if (udp_rec_data_valid) begin
          if (udp_rec_data_length < MIN_LEN
              || udp_rec_rdata != RTP_VPXCC) begin
            drop_inc = 1'b1;
            state_n  = (udp_rec_data_length <= 16'd1) ? S_IDLE : S_DROP;
          end else begin
            state_n = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (udp_rec_data_valid) begin
          if (hdr_bad) begin
            drop_inc = 1'b1;
            state_n  = S_DROP;
          end else if (idx == HDR_LAST) begin
            hdr_done = 1'b1;
            state_n  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (udp_rec_data_valid) begin
          push = idx[0];
          if (last) state_n = S_IDLE;
        end
      end
      S_DROP: begin
        if (udp_rec_data_valid && last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // stalled mid-packet: abort, counting it unless DROP already did
    if (timeout) begin
      state_n  = S_IDLE;
      drop_inc = (state != S_DROP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len          <= '0;
      idx          <= '0;
      seq          <= '0;
      exp_seq      <= '0;
      exp_valid    <= 1'b0;
      hi           <= '0;
      to_cnt       <= '0;
      wav_out_data <= '0;
      playing      <= 1'b0;
      pkt_drop_cnt <= '0;
      seq_gap_cnt  <= '0;
      underrun_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      state <= state_n;
      if (udp_rec_data_valid) begin
        idx <= (state == S_IDLE) ? 16'd1 : idx + 16'd1;
      end
      if (udp_rec_data_valid || state == S_IDLE || timeout) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (udp_rec_data_valid && state == S_IDLE) begin
        len <= udp_rec_data_length;
      end
      if (udp_rec_data_valid && state == S_HDR) begin
        if (idx == SEQ_HI) seq[15:8] <= udp_rec_rdata;
        if (idx == SEQ_LO) seq[7:0]  <= udp_rec_rdata;
      end
      if (udp_rec_data_valid && state == S_PAYLOAD && !idx[0]) begin
        hi <= udp_rec_rdata;
      end
      if (hdr_done) begin
        if (exp_valid && seq != exp_seq) seq_gap_cnt <= sat_inc(seq_gap_cnt);
        exp_seq   <= seq + 16'd1;
        exp_valid <= 1'b1;
      end
      if (drop_inc) pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
      if (push && full && !pop_req) overflow_cnt <= sat_inc(overflow_cnt);
      if (wav_rden) begin
        if (!playing) begin
          wav_out_data <= '0;
        end else if (empty) begin
          wav_out_data <= '0;
          underrun_cnt <= sat_inc(underrun_cnt);
          playing      <= 1'b0;
        end else begin
          wav_out_data <= head;
        end
      end
      if (!playing && level >= PRE_LVL) playing <= 1'b1;
    end
  end

endmodule
